// File: rtl/keccak_pkg.sv
// ============================================================================
// Module   : keccak_pkg
// Brief    : Shared geometry and driver state encoding for the Keccak driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keccak_pkg;

    localparam int LANES     = 25;
    localparam int DATA_BITS = 64;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD       = 3'd1;
    localparam logic [2:0] KICK       = 3'd2;
    localparam logic [2:0] WAIT_VALID = 3'd3;
    localparam logic [2:0] CAPTURE    = 3'd4;
    localparam logic [2:0] WAIT_DONE  = 3'd5;
    localparam logic [2:0] DRAIN      = 3'd6;
    localparam logic [2:0] ERR        = 3'd7;

endpackage

`default_nettype wire

// File: rtl/lane_buffer.sv
// ============================================================================
// Module   : lane_buffer
// Brief    : LANES x DATA_BITS register file, one write port, one async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_buffer
    import keccak_pkg::*;
#(
    parameter int AW = $clog2(LANES + 1)
) (
    input  logic                 CLK,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [DATA_BITS-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [DATA_BITS-1:0] o_rd_data
);

    localparam logic [AW-1:0] c_DEPTH = AW'(LANES);

    // Contents survive reset on purpose: a short result keeps older lanes.
    logic [DATA_BITS-1:0] r_mem [LANES];

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = (i_rd_addr < c_DEPTH) ? r_mem[i_rd_addr] : '0;

endmodule

`default_nettype wire

// File: rtl/keccak_driver.sv
// ============================================================================
// Module   : keccak_driver
// Brief    : Loads 25 lanes into the Keccak core, starts it, captures and
//            drains the result lanes to the host with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_driver
    import keccak_pkg::*;
#(
    parameter int SKEW    = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 s_valid,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [DATA_BITS-1:0] m_data,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_short,
    output logic                 core_start,
    output logic                 core_we,
    output logic [DATA_BITS-1:0] core_din,
    input  logic                 core_valid,
    input  logic [DATA_BITS-1:0] core_dout,
    input  logic                 core_done
);

    localparam int              c_CW     = $clog2(LANES + 1);
    localparam int              c_WW     = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(LANES - 1);
    localparam logic [c_CW-1:0] c_FULL   = c_CW'(LANES);
    localparam logic [c_WW-1:0] c_WD_MAX = c_WW'(TIMEOUT);

    logic [2:0]           r_state, w_state_nxt;
    logic [c_CW-1:0]      r_ld_cnt, r_cap_cnt, r_rd_cnt, w_rd_addr, w_cap_nxt;
    logic [c_WW-1:0]      r_wd;
    logic [SKEW-1:0]      r_vld_dly;
    logic                 r_s_ready, r_m_valid, r_busy, r_err_timeout, r_err_short;
    logic                 r_core_start, r_core_we;
    logic [DATA_BITS-1:0] r_m_data, r_core_din, w_buf_data, w_rd_data;
    logic                 w_s_hs, w_m_hs, w_cap, w_wd_exp, w_vld_in;

    assign w_s_hs    = s_valid & r_s_ready;
    assign w_m_hs    = r_m_valid & m_ready;
    assign w_wd_exp  = (r_wd == c_WD_MAX);
    assign w_vld_in  = core_valid & ((r_state == WAIT_VALID) | (r_state == CAPTURE));
    assign w_cap     = (r_state == CAPTURE) & r_vld_dly[SKEW-1] & (r_cap_cnt != c_FULL);
    assign w_cap_nxt = r_cap_cnt + c_CW'(w_cap);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (w_s_hs) w_state_nxt = LOAD;
            LOAD:       if (w_s_hs && (r_ld_cnt == c_LAST)) w_state_nxt = KICK;
            KICK:       w_state_nxt = WAIT_VALID;
            WAIT_VALID: begin
                if (core_valid)    w_state_nxt = CAPTURE;
                else if (w_wd_exp) w_state_nxt = ERR;
            end
            // A same-cycle last lane is still written before leaving.
            CAPTURE: begin
                if (core_done)                w_state_nxt = DRAIN;
                else if (w_cap_nxt == c_FULL) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (core_done)     w_state_nxt = DRAIN;
                else if (w_wd_exp) w_state_nxt = ERR;
            end
            DRAIN:      if (w_m_hs && (r_rd_cnt == c_LAST)) w_state_nxt = IDLE;
            ERR:        w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // Read address for the lane presented next; bypass covers a lane written this cycle.
    always_comb begin
        w_rd_addr = r_rd_cnt;
        if (r_state != DRAIN) w_rd_addr = '0;
        else if (w_m_hs)      w_rd_addr = r_rd_cnt + 1'b1;
    end

    assign w_rd_data = (w_cap && (r_cap_cnt == w_rd_addr)) ? core_dout : w_buf_data;

    lane_buffer #(
        .AW        (c_CW)
    ) u_lane_buffer (
        .CLK       (CLK),
        .i_wr_en   (w_cap),
        .i_wr_addr (r_cap_cnt),
        .i_wr_data (core_dout),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_buf_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_ld_cnt      <= '0;
            r_cap_cnt     <= '0;
            r_rd_cnt      <= '0;
            r_wd          <= '0;
            r_vld_dly     <= '0;
            r_s_ready     <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_short   <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_we     <= 1'b0;
            r_core_din    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_s_ready    <= (w_state_nxt == IDLE) || (w_state_nxt == LOAD);
            r_m_valid    <= (w_state_nxt == DRAIN);
            r_core_we    <= w_s_hs;
            r_core_start <= (r_state == KICK);

            r_vld_dly[0] <= w_vld_in;
            for (int i = 1; i < SKEW; i++) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
            end

            if (w_s_hs) begin
                r_core_din <= s_data;
                r_ld_cnt   <= (r_state == IDLE) ? c_CW'(1) : r_ld_cnt + 1'b1;
            end

            if (r_state == KICK) r_cap_cnt <= '0;
            else if (w_cap)      r_cap_cnt <= w_cap_nxt;

            if ((w_state_nxt == DRAIN) && (r_state != DRAIN)) r_rd_cnt <= '0;
            else if (w_m_hs)                                   r_rd_cnt <= r_rd_cnt + 1'b1;

            if (w_state_nxt == DRAIN) r_m_data <= w_rd_data;

            if (w_state_nxt != r_state) begin
                r_wd <= '0;
            end else if (((r_state == WAIT_VALID) && !core_valid) ||
                         ((r_state == WAIT_DONE) && !core_done)) begin
                r_wd <= r_wd + 1'b1;
            end

            if ((r_state == IDLE) && w_s_hs) begin
                r_err_timeout <= 1'b0;
                r_err_short   <= 1'b0;
            end
            if (r_state == ERR) r_err_timeout <= 1'b1;
            if ((r_state == CAPTURE) && core_done && (w_cap_nxt != c_FULL)) r_err_short <= 1'b1;
        end
    end

    assign s_ready     = r_s_ready;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign busy        = r_busy;
    assign err_timeout = r_err_timeout;
    assign err_short   = r_err_short;
    assign core_start  = r_core_start;
    assign core_we     = r_core_we;
    assign core_din    = r_core_din;

endmodule

`default_nettype wire

// File: doc/keccak_driver.md
Name: keccak_driver

Overview:
Initiator-side controller for the Keccak permutation core, opposite the core's load/compute/unload interface.
- Accepts 25 input lanes from a host stream and writes them into the core with `we`/`din`.
- Pulses `start`, then captures the 25 result lanes the core emits under `valid`/`dout`.
- Buffers the result lanes and streams them back to the host with backpressure; the core itself cannot be stalled.
- Sits between the RISC-V load/store glue and the Keccak core.

Parameters:
- LANES, 25, number of 64-bit state lanes per permutation.
- DATA_BITS, 64, lane width.
- SKEW, 1, cycles from core_valid high to the matching lane on core_dout (core registers dout).
- TIMEOUT, 1023, maximum cycles allowed in WAIT_VALID or WAIT_DONE before aborting.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- s_valid  in  1  host input lane valid.
- s_data  in  DATA_BITS  host input lane.
- s_ready  out  1  driver accepts an input lane this cycle.
- m_valid  out  1  result lane available.
- m_data  out  DATA_BITS  result lane.
- m_ready  in  1  host takes the result lane.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky; the watchdog expired.
- err_short  out  1  sticky; core_done arrived before LANES lanes were captured.
- core_start  out  1  one-cycle start pulse to the core.
- core_we  out  1  lane write enable to the core.
- core_din  out  DATA_BITS  lane data to the core.
- core_valid  in  1  core output phase active.
- core_dout  in  DATA_BITS  core output lane.
- core_done  in  1  core finished.

Behaviour:
- **Reset:** RST low asynchronously forces all of the following, regardless of the current state (including mid-load or mid-drain); buffer contents are not cleared.
  - state = IDLE.
  - all counters = 0.
  - s_ready = 0, m_valid = 0, m_data = 0.
  - core_start = 0, core_we = 0, core_din = 0.
  - busy = 0, err_timeout = 0, err_short = 0.
- **Registered outputs:** all outputs are registered.
- **IDLE:**
  - s_ready = 1.
  - On the first s_valid & s_ready: clear err_timeout and err_short, move to LOAD, and count this lane as lane 0.
- **LOAD:**
  - Each s_valid & s_ready handshake registers core_we = 1 and core_din = s_data on the next cycle; latency is 1 cycle.
  - Gaps in s_valid produce core_we = 0 cycles.
  - ld_cnt counts 0..LANES-1.
  - After the handshake at ld_cnt = LANES-1: s_ready drops and the state moves to KICK.
- **KICK:** core_start = 1 for exactly one cycle, issued one cycle after the last core_we; then WAIT_VALID.
- **WAIT_VALID:**
  - Watchdog counts while core_valid = 0.
  - On the first core_valid = 1: go to CAPTURE.
  - If the watchdog reaches TIMEOUT: go to ERR.
- **CAPTURE:**
  - core_valid is delayed SKEW cycles through a shift register; the delayed valid enables writing core_dout into the buffer at cap_cnt, then cap_cnt increments.
  - Capture stops at cap_cnt = LANES; extra valid cycles are ignored.
  - The core's last capture and core_done can land in the same cycle. Both must take effect: the lane is written, then the state moves to DRAIN.
  - core_done seen without the same-cycle capture: go to DRAIN, or to WAIT_DONE if cap_cnt = LANES.
  - core_done with cap_cnt < LANES after the same-cycle write: set err_short, then go to DRAIN. Uncaptured slots hold stale data.
- **WAIT_DONE:**
  - Waits for core_done under the same watchdog.
  - core_done: go to DRAIN.
  - Watchdog reaches TIMEOUT: go to ERR.
- **DRAIN:**
  - m_valid = 1 with m_data = buffer[rd_cnt].
  - rd_cnt advances on m_valid & m_ready.
  - m_data holds stable while m_ready = 0.
  - After the handshake at rd_cnt = LANES-1: m_valid drops and the state returns to IDLE.
- **ERR:**
  - Set err_timeout.
  - Keep core_start = 0.
  - Go to IDLE in one cycle; nothing is drained.
- **Widths:**
  - Counters are ceil(log2(LANES+1)) bits; wrap-around is impossible by construction.
  - Watchdog is ceil(log2(TIMEOUT+1)) bits and clears on every state entry.

Decomposition:
- Shared package keccak_pkg holds:
  - LANES, DATA_BITS.
  - the driver state encoding: IDLE, LOAD, KICK, WAIT_VALID, CAPTURE, WAIT_DONE, DRAIN, ERR.
- One sub-module, lane_buffer: a LANES x DATA_BITS register file with one write port (addr, data, we) and one combinational read port.

Test Plan:
- **Back-to-back load:** stream lanes 0x0..0x18 with s_valid held high.
  - core_we is high for exactly 25 consecutive cycles with core_din = 0x0..0x18.
  - core_start pulses once, one cycle after the last core_we.
- **Gapped load:** s_valid toggles every other cycle → still 25 core_we beats in order, then one start pulse.
- **Capture with skew:** core model drives core_valid for 25 cycles, core_dout = 0xA000+i delayed 1 cycle, and core_done coincident with the last lane.
  - Drain yields 0xA000..0xA018.
  - err_short = 0.
- **Backpressure:** m_ready held low for 10 cycles mid-drain at rd_cnt = 7 → m_data stays 0xA007 throughout, with no lane lost or duplicated.
- **Timeout:** core never asserts core_valid.
  - After TIMEOUT + 1 cycles in WAIT_VALID, err_timeout = 1 and the state is IDLE.
  - The next accepted s_valid clears err_timeout.
- **Short/reset:**
  - core_done after 20 valid cycles → err_short = 1, and 25 lanes are drained.
  - RST asserted mid-DRAIN → m_valid = 0 and busy = 0 immediately (asynchronously).
